i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master engine between two register-access requesters.
- Requester 0 is the power-up configuration sequencer. Requester 1 is the runtime register port (exposure/gain/AWB tweaks, status reads).
- Sits between the requesters and the I2C master. Runs on the I2C driver clock.
- Serialises transactions with round-robin fairness and returns read data and completion to the owner.

Parameters:
- ADDR_W, 16, register address width passed to the I2C master.
- TIMEOUT_CYC, 20'd100000, clk cycles allowed in WAIT before a transaction is aborted. Used only with I2C_TIMEOUT_EN.

Ports:
- clk  in  1  I2C driver clock (dri_clk of the I2C master).
- rst_n  in  1  reset; asynchronous assert, active-low.
- req0  in  1  requester 0 transaction request, single-cycle pulse.
- rh_wl0  in  1  requester 0 direction: 1 = read, 0 = write.
- addr0  in  ADDR_W  requester 0 register address.
- wdata0  in  8  requester 0 write data.
- busy0  out  1  requester 0 has a pending or in-service transaction.
- done0  out  1  requester 0 transaction finished, one-cycle pulse.
- err0  out  1  qualifies done0: transaction timed out.
- rdata0  out  8  requester 0 read data, valid from done0 until the next requester-0 done.
- req1, rh_wl1, addr1, wdata1, busy1, done1, err1, rdata1: same as requester 0, for requester 1.
- i2c_exec  out  1  start pulse to the I2C master.
- i2c_rh_wl  out  1  direction to the I2C master.
- i2c_addr  out  ADDR_W  register address to the I2C master.
- i2c_data_w  out  8  write data to the I2C master.
- i2c_data_r  in  8  read data from the I2C master.
- i2c_done  in  1  I2C master completion pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; pend0 = pend1 = 0; rr_ptr = 0 (requester 0 favoured first).
- Request capture:
  - reqN=1 while busyN=0: sets pendN and latches rh_wl/addr/wdata into a per-requester holding register.
  - reqN=1 while busyN=1: ignored; the holding register is unchanged.
  - busyN = pendN OR (in-service owner == N).
- State IDLE:
  - Neither pend set: stay in IDLE.
  - One pend set: grant that requester.
  - Both set: grant the requester selected by rr_ptr.
  - On grant: copy the holding register to i2c_rh_wl/i2c_addr/i2c_data_w, clear the winner's pend, record the owner, go to ISSUE.
  - A reqN arriving in the same cycle is only latched; it can be granted from the next cycle.
- State ISSUE: i2c_exec=1 for exactly one cycle; go to WAIT.
- State WAIT:
  - Hold i2c_rh_wl/addr/data_w stable.
  - On i2c_done=1: latch i2c_data_r into rdataOwner (write transactions latch it too, value unspecified), go to DONE.
  - i2c_done while not in WAIT is ignored.
- State DONE:
  - doneOwner=1 for one cycle; errOwner=0.
  - rr_ptr = ~owner.
  - Clear owner; go to IDLE.
- Latency, req pulse to i2c_exec with the bus idle: 2 cycles (capture, IDLE grant, ISSUE). Latency, i2c_done to doneN: 1 cycle.
- Back-to-back: a requester may pulse req in the same cycle as its doneN. busyN falls in that cycle, so the pulse is accepted.
- Fairness: with both requesters continuously re-requesting, grants alternate 0, 1, 0, 1.
- Reset mid-transaction:
  - All state clears immediately.
  - No done pulses are generated.
  - A late i2c_done after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - A 20-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 with no i2c_done: go to DONE with errOwner=1 and rdataOwner=8'h00, then continue normally.
  - i2c_done in the same cycle as expiry takes precedence (err=0).
- Not defined: no counter; WAIT holds until i2c_done; err0/err1 are tied to 0.

Test Plan:
- Single write: req0 with rh_wl0=0, addr0=16'h3008, wdata0=8'h02 -> i2c_exec 2 cycles later with i2c_addr=16'h3008 and i2c_data_w=8'h02; bench returns i2c_done 50 cycles later -> done0 1 cycle later, err0=0, busy0 low.
- Read: req1 with rh_wl1=1, addr1=16'h300A; bench returns i2c_data_r=8'h56 with i2c_done -> done1 pulse, rdata1=8'h56, rdata0 unchanged.
- Simultaneous: req0 and req1 in the same cycle after reset -> requester 0 served first, then requester 1. Both re-request on every done -> grant order 0, 1, 0, 1 over 4 transactions.
- Busy reject: req0 addr 16'h3800, then req0 addr 16'h3801 while busy0=1 -> only 16'h3800 is issued; exactly one done0.
- Reset mid-WAIT: assert rst_n=0 during WAIT, release, then pulse i2c_done -> no done0/done1; all outputs 0; the next req issues normally.
- With I2C_TIMEOUT_EN, TIMEOUT_CYC=64: req0 with no i2c_done -> done0 and err0 high 64 cycles after entering WAIT, rdata0=8'h00; a pending req1 is then granted.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin arbiter sharing one I2C master engine between
// two register-access requesters (0 = power-up sequencer, 1 = runtime port).
// Optional feature macro: I2C_TIMEOUT_EN (WAIT timeout with err reporting).
module i2c_bus_arbiter #(
    parameter int unsigned ADDR_W = 16
`ifdef I2C_TIMEOUT_EN
    ,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              rh_wl0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [7:0]        wdata0,
    output logic              busy0,
    output logic              done0,
    output logic              err0,
    output logic [7:0]        rdata0,
    input  logic              req1,
    input  logic              rh_wl1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata1,
    output logic              busy1,
    output logic              done1,
    output logic              err1,
    output logic [7:0]        rdata1,
    output logic              i2c_exec,
    output logic              i2c_rh_wl,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [7:0]        i2c_data_w,
    input  logic [7:0]        i2c_data_r,
    input  logic              i2c_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          pend_q, pend_d;
    logic                owner_q, owner_d;
    logic                own_vld_q, own_vld_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                win;
    logic [1:0]          acc;
    logic                hold_rh_wl_q [2];
    logic [ADDR_W-1:0]   hold_addr_q  [2];
    logic [7:0]          hold_wdata_q [2];
    logic                exec_d, rh_wl_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [7:0]          data_w_d, rdata0_d, rdata1_d;
    logic [1:0]          done_d, err_d, busy_d;
`ifdef I2C_TIMEOUT_EN
    logic [19:0]         tmo_q, tmo_d;
`endif

    // A request is accepted only while its requester is not busy
    assign acc = {req1 & ~busy1, req0 & ~busy0};

    // Per-requester holding registers, loaded on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hold_rh_wl_q[i] <= 1'b0;
                hold_addr_q[i]  <= '0;
                hold_wdata_q[i] <= 8'h00;
            end
        end else begin
            if (acc[0]) begin
                hold_rh_wl_q[0] <= rh_wl0;
                hold_addr_q[0]  <= addr0;
                hold_wdata_q[0] <= wdata0;
            end
            if (acc[1]) begin
                hold_rh_wl_q[1] <= rh_wl1;
                hold_addr_q[1]  <= addr1;
                hold_wdata_q[1] <= wdata1;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q | acc;
        owner_d   = owner_q;
        own_vld_d = own_vld_q;
        rr_ptr_d  = rr_ptr_q;
        win       = 1'b0;
        exec_d    = 1'b0;
        rh_wl_d   = i2c_rh_wl;
        addr_d    = i2c_addr;
        data_w_d  = i2c_data_w;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata0_d  = rdata0;
        rdata1_d  = rdata1;
`ifdef I2C_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    win         = (pend_q == 2'b11) ? rr_ptr_q : pend_q[1];
                    pend_d[win] = 1'b0;
                    rh_wl_d     = hold_rh_wl_q[win];
                    addr_d      = hold_addr_q[win];
                    data_w_d    = hold_wdata_q[win];
                    owner_d     = win;
                    own_vld_d   = 1'b1;
                    exec_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef I2C_TIMEOUT_EN
                tmo_d   = 20'd0;
`endif
            end
            S_WAIT: begin
                if (i2c_done) begin
                    if (owner_q) rdata1_d = i2c_data_r;
                    else         rdata0_d = i2c_data_r;
                    done_d[owner_q] = 1'b1;
                    own_vld_d       = 1'b0;
                    state_d         = S_DONE;
                end
`ifdef I2C_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYC - 20'd1) begin
                    if (owner_q) rdata1_d = 8'h00;
                    else         rdata0_d = 8'h00;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    own_vld_d       = 1'b0;
                    state_d         = S_DONE;
                end else begin
                    tmo_d = tmo_q + 20'd1;
                end
`endif
            end
            S_DONE: begin
                rr_ptr_d = ~owner_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Owner is released on entry to DONE so busy drops in the done cycle
        busy_d = pend_d | {own_vld_d & owner_d, own_vld_d & ~owner_d};
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pend_q     <= 2'b00;
            owner_q    <= 1'b0;
            own_vld_q  <= 1'b0;
            rr_ptr_q   <= 1'b0;
            i2c_exec   <= 1'b0;
            i2c_rh_wl  <= 1'b0;
            i2c_addr   <= '0;
            i2c_data_w <= 8'h00;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
            busy0      <= 1'b0;
            busy1      <= 1'b0;
`ifdef I2C_TIMEOUT_EN
            tmo_q      <= 20'd0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            own_vld_q  <= own_vld_d;
            rr_ptr_q   <= rr_ptr_d;
            i2c_exec   <= exec_d;
            i2c_rh_wl  <= rh_wl_d;
            i2c_addr   <= addr_d;
            i2c_data_w <= data_w_d;
            done0      <= done_d[0];
            done1      <= done_d[1];
            err0       <= err_d[0];
            err1       <= err_d[1];
            rdata0     <= rdata0_d;
            rdata1     <= rdata1_d;
            busy0      <= busy_d[0];
            busy1      <= busy_d[1];
`ifdef I2C_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter.
module tb_i2c_bus_arbiter;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, rh_wl0, req1, rh_wl1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [7:0]        wdata0, wdata1;
    logic              busy0, done0, err0, busy1, done1, err1;
    logic [7:0]        rdata0, rdata1;
    logic              i2c_exec, i2c_rh_wl;
    logic [ADDR_W-1:0] i2c_addr;
    logic [7:0]        i2c_data_w, i2c_data_r;
    logic              i2c_done;

    int checks   = 0;
    int failures = 0;

    i2c_bus_arbiter #(
        .ADDR_W(ADDR_W)
`ifdef I2C_TIMEOUT_EN
        , .TIMEOUT_CYC(20'd64)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rh_wl0(rh_wl0), .addr0(addr0), .wdata0(wdata0),
        .busy0(busy0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .rh_wl1(rh_wl1), .addr1(addr1), .wdata1(wdata1),
        .busy1(busy1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
        .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input string tag);
        int n = 0;
        while (!i2c_exec && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, 32'(i2c_exec), 32'd1);
    endtask

    // Leave the I2C master busy a few cycles, then return data with i2c_done;
    // returns sampling the DONE cycle
    task automatic complete(input logic [7:0] d);
        repeat (4) cyc();
        i2c_data_r = d;
        i2c_done   = 1'b1;
        cyc();
        i2c_done   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; rh_wl0 = 1'b0; addr0 = '0; wdata0 = 8'h00;
        req1 = 1'b0; rh_wl1 = 1'b0; addr1 = '0; wdata1 = 8'h00;
        i2c_data_r = 8'h00; i2c_done = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int extra;
        int exp_req;
        int n;

        // Reset state
        do_reset();
        chk("rst_exec",  32'(i2c_exec), 32'd0);
        chk("rst_busy",  32'({busy1, busy0}), 32'd0);
        chk("rst_done",  32'({done1, done0}), 32'd0);
        chk("rst_err",   32'({err1, err0}), 32'd0);
        chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
        chk("rst_addr",  32'(i2c_addr), 32'd0);

        // Single write from requester 0: exec exactly 2 cycles after the pulse
        req0 = 1'b1; rh_wl0 = 1'b0; addr0 = 16'h3008; wdata0 = 8'h02;
        cyc();
        req0 = 1'b0;
        chk("wr_busy_up",   32'(busy0), 32'd1);
        chk("wr_exec_early", 32'(i2c_exec), 32'd0);
        cyc();
        chk("wr_exec",  32'(i2c_exec), 32'd1);
        chk("wr_addr",  32'(i2c_addr), 32'h3008);
        chk("wr_data",  32'(i2c_data_w), 32'h02);
        chk("wr_dir",   32'(i2c_rh_wl), 32'd0);
        cyc();
        chk("wr_exec_1cyc", 32'(i2c_exec), 32'd0);
        repeat (48) cyc();
        chk("wr_addr_hold", 32'(i2c_addr), 32'h3008);
        chk("wr_no_early_done", 32'(done0), 32'd0);
        i2c_data_r = 8'hAA; i2c_done = 1'b1;
        cyc();
        i2c_done = 1'b0;
        chk("wr_done",  32'(done0), 32'd1);
        chk("wr_err",   32'(err0), 32'd0);
        chk("wr_busy_down", 32'(busy0), 32'd0);
        chk("wr_done1_quiet", 32'(done1), 32'd0);
        cyc();
        chk("wr_done_pulse", 32'(done0), 32'd0);

        // Read from requester 1
        req1 = 1'b1; rh_wl1 = 1'b1; addr1 = 16'h300A;
        cyc();
        req1 = 1'b0;
        wait_exec("rd_exec");
        chk("rd_addr", 32'(i2c_addr), 32'h300A);
        chk("rd_dir",  32'(i2c_rh_wl), 32'd1);
        complete(8'h56);
        chk("rd_done1",  32'(done1), 32'd1);
        chk("rd_done0",  32'(done0), 32'd0);
        chk("rd_rdata1", 32'(rdata1), 32'h56);
        chk("rd_rdata0_kept", 32'(rdata0), 32'hAA);
        cyc();

        // Simultaneous requests after reset, with re-requests on done
        do_reset();
        addr0 = 16'h1000; addr1 = 16'h2000; rh_wl0 = 1'b0; rh_wl1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_req = k % 2;
            wait_exec($sformatf("rr_exec%0d", k));
            chk($sformatf("rr_addr%0d", k), 32'(i2c_addr),
                (exp_req == 1) ? 32'h2000 : 32'h1000);
            complete(8'(k));
            chk($sformatf("rr_done%0d", k), 32'({done1, done0}),
                (exp_req == 1) ? 32'd2 : 32'd1);
            chk($sformatf("rr_busy_free%0d", k),
                (exp_req == 1) ? 32'(busy1) : 32'(busy0), 32'd0);
            if (k < 2) begin
                if (exp_req == 1) req1 = 1'b1;
                else              req0 = 1'b1;
            end
            cyc();
            req0 = 1'b0; req1 = 1'b0;
        end
        repeat (3) cyc();

        // Request while busy is dropped
        req0 = 1'b1; addr0 = 16'h3800;
        cyc();
        addr0 = 16'h3801;
        cyc();
        req0 = 1'b0;
        wait_exec("busy_exec");
        chk("busy_addr", 32'(i2c_addr), 32'h3800);
        complete(8'h11);
        chk("busy_done", 32'(done0), 32'd1);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (done0 || i2c_exec) extra++;
        end
        chk("busy_single", 32'(extra), 32'd0);

        // Reset during WAIT, then a stray i2c_done
        req1 = 1'b1; rh_wl1 = 1'b1; addr1 = 16'h4000;
        cyc();
        req1 = 1'b0;
        wait_exec("mid_exec");
        cyc();
        rst_n = 1'b0;
        #2;
        chk("mid_async_busy", 32'({busy1, busy0}), 32'd0);
        chk("mid_async_addr", 32'(i2c_addr), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        i2c_data_r = 8'h77; i2c_done = 1'b1;
        cyc();
        i2c_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (done0 || done1 || i2c_exec) extra++;
            cyc();
        end
        chk("mid_no_done", 32'(extra), 32'd0);
        chk("mid_rdata1", 32'(rdata1), 32'd0);
        chk("mid_busy",   32'({busy1, busy0}), 32'd0);
        req0 = 1'b1; rh_wl0 = 1'b1; addr0 = 16'h5000;
        cyc();
        req0 = 1'b0;
        wait_exec("post_exec");
        chk("post_addr", 32'(i2c_addr), 32'h5000);
        complete(8'h33);
        chk("post_done",  32'(done0), 32'd1);
        chk("post_rdata", 32'(rdata0), 32'h33);
        cyc();

`ifdef I2C_TIMEOUT_EN
        // Timeout with a pending requester 1 behind it
        req0 = 1'b1; addr0 = 16'h6000;
        cyc();
        req0 = 1'b0; req1 = 1'b1; addr1 = 16'h6001;
        cyc();
        req1 = 1'b0;
        wait_exec("tmo_exec");
        cyc();
        n = 0;
        while (!done0 && n < 100) begin
            cyc();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd64);
        chk("tmo_err",     32'(err0), 32'd1);
        chk("tmo_rdata",   32'(rdata0), 32'd0);
        wait_exec("tmo_next_exec");
        chk("tmo_next_addr", 32'(i2c_addr), 32'h6001);
        complete(8'h5A);
        chk("tmo_next_done", 32'(done1), 32'd1);
        chk("tmo_next_err",  32'(err1), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
